// File: rtl/mem_bus_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the data-port memory responder.
//   state_t  : responder FSM states (IDLE / WAIT / RESP)
//   BE_W     : byte-enable width (bytes per word)
//   WORD_W   : data word width in bits
//   addr_err : alignment / range check for a byte address
// ---------------------------------------------------------------------------
package mem_bus_pkg;

    localparam int BE_W   = 4;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A request is rejected when it is not word aligned or when its word
    // index falls outside the stored array.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                      input logic [WORD_W-1:0] depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// ---------------------------------------------------------------------------
// mem_word_array
// DEPTH_WORDS x 32-bit storage with a byte-enabled synchronous write and a
// registered read. Contents are never reset.
// Ports:
//   clk      : clock
//   i_en     : access strobe; read and (optional) write happen on this edge
//   i_we     : 1 = write enabled bytes, 0 = read only
//   i_idx    : word index
//   i_wdata  : write data
//   i_be     : byte enables, bit b covers bits 8b+7:8b
//   o_rdata  : word read on the last strobed edge (held otherwise)
// ---------------------------------------------------------------------------
module mem_word_array
    import mem_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_idx,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end
            // Old-data read; only meaningful for loads, stores ignore it.
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the core data port. Accepts one load/store at a
// time, waits LATENCY cycles, performs the access into mem_word_array and
// presents a response until it is consumed.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (req_ready = state is IDLE)
//   req_write             : 1 = store, 0 = load
//   req_addr              : byte address
//   req_wdata, req_be     : store data and byte enables
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata             : load data (0 for stores and errors)
//   rsp_err               : misaligned or out-of-range request
// ---------------------------------------------------------------------------
module data_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_write;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              r_rd_sel;      // response carries array read data

    logic              w_access;
    logic              w_err;
    logic [WORD_W-1:0] w_rdata;

    // The access happens on the edge where the wait counter has run out.
    assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_err    = addr_err(r_addr, 32'(DEPTH_WORDS));

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_en    (w_access && !w_err),
        .i_we    (r_write),
        .i_idx   (r_addr[AW+1:2]),
        .i_wdata (r_wdata),
        .i_be    (r_be),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rd_sel    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_be    <= req_be;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rd_sel    <= !w_err && !r_write;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rd_sel    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Decoded from state only, so there is no path from req_valid.
    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    // Array output only changes on an access strobe, so it is stable in RESP.
    assign rsp_rdata = r_rd_sel ? w_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;
    localparam int NB    = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    // DUT A: LATENCY=2
    logic        a_req_valid = 0, a_req_write = 0, a_rsp_ready = 0;
    logic [31:0] a_req_addr = 0, a_req_wdata = 0;
    logic [3:0]  a_req_be = 0;
    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;

    // DUT B: LATENCY=1, used for back-to-back throughput
    logic        b_req_valid = 0, b_req_write = 0, b_rsp_ready = 0;
    logic [31:0] b_req_addr = 0, b_req_wdata = 0;
    logic [3:0]  b_req_be = 0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .reset(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .reset(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mdl_a [DEPTH];
    logic [31:0] mdl_b [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference rules: word address space is DEPTH words of 4 bytes.
    function automatic bit ref_err(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= DEPTH);
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] be);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) if (be[i]) res[8*i +: 8] = d[8*i +: 8];
        return res;
    endfunction

    // One transaction on DUT A; called 1 time unit after a rising edge with A idle.
    task automatic txn_a(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input int stall,
                         output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          cyc;
        exp_er = ref_err(a);
        exp_rd = (w || exp_er) ? 32'h0 : mdl_a[a / 4];
        chk("req_ready_idle", 32'(a_req_ready), 32'h1);
        a_req_valid = 1; a_req_write = w; a_req_addr = a; a_req_wdata = d; a_req_be = be;
        a_rsp_ready = (stall == 0);
        @(posedge clk); #1;
        a_req_valid = 0;
        a_req_write = 1'($urandom); a_req_addr = $urandom; a_req_wdata = $urandom;
        a_req_be = 4'($urandom);
        cyc = 0;
        while (!a_rsp_valid && cyc < 20) begin
            chk("wait_ready_low", 32'(a_req_ready), 32'h0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(LAT_A));
        chk("rsp_err", 32'(a_rsp_err), 32'(exp_er));
        chk("rsp_rdata", a_rsp_rdata, exp_rd);
        rd = a_rsp_rdata;
        er = a_rsp_err;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(a_rsp_valid), 32'h1);
            chk("stall_rdata", a_rsp_rdata, exp_rd);
            chk("stall_err", 32'(a_rsp_err), 32'(exp_er));
            chk("stall_req_ready", 32'(a_req_ready), 32'h0);
        end
        a_rsp_ready = 1;
        @(posedge clk); #1;
        chk("rsp_dropped", 32'(a_rsp_valid), 32'h0);
        chk("ready_after_consume", 32'(a_req_ready), 32'h1);
        a_rsp_ready = 0;
        if (w && !exp_er) mdl_a[a / 4] = ref_merge(mdl_a[a / 4], d, be);
        $display("txn A %s addr=%h wdata=%h be=%h stall=%0d -> rdata=%h err=%0d",
                 w ? "ST" : "LD", a, d, be, stall, rd, er);
    endtask

    logic [31:0] rd;
    logic        er;

    // Back-to-back program for DUT B
    bit          op_w [NB];
    logic [31:0] op_a [NB];
    logic [31:0] op_d [NB];
    logic [31:0] exp_q_rd [$];
    logic        exp_q_er [$];

    initial begin
        // ---- reset state ----
        #2 rst_n = 0;
        #1;
        chk("rst_req_ready", 32'(a_req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'h0);
        chk("rst_rsp_rdata", a_rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(a_rsp_err), 32'h0);
        chk("rst_b_req_ready", 32'(b_req_ready), 32'h1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #1;

        // ---- fill every word of A so later loads are defined ----
        for (int i = 0; i < DEPTH; i++) txn_a(1, 32'(i * 4), $urandom, 4'hF, 0, rd, er);

        // ---- directed ----
        txn_a(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
        txn_a(0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        chk("load_deadbeef", rd, 32'hDEADBEEF);
        txn_a(1, 32'h10, 32'h000000AA, 4'h1, 0, rd, er);
        txn_a(0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        chk("load_be1", rd, 32'hDEADBEAA);
        txn_a(0, 32'h12, 32'h0, 4'h0, 0, rd, er);
        chk("misaligned_err", 32'(er), 32'h1);
        txn_a(0, 32'(DEPTH * 4), 32'h0, 4'h0, 0, rd, er);
        chk("range_err", 32'(er), 32'h1);
        txn_a(1, 32'h13, 32'h11223344, 4'hF, 0, rd, er);
        chk("store_err", 32'(er), 32'h1);
        txn_a(0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        chk("after_bad_store", rd, 32'hDEADBEAA);
        txn_a(1, 32'h14, 32'hCAFEF00D, 4'h0, 0, rd, er);
        chk("be0_ok", 32'(er), 32'h0);
        txn_a(0, 32'h10, 32'h0, 4'h0, 5, rd, er);

        // ---- reset during WAIT discards uncommitted store ----
        a_req_valid = 1; a_req_write = 1; a_req_addr = 32'h20;
        a_req_wdata = 32'h12345678; a_req_be = 4'hF; a_rsp_ready = 1;
        @(posedge clk); #1;
        a_req_valid = 0;
        chk("in_wait", 32'(a_req_ready), 32'h0);
        rst_n = 0;
        #1;
        chk("midrst_rsp_valid", 32'(a_rsp_valid), 32'h0);
        chk("midrst_req_ready", 32'(a_req_ready), 32'h1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        a_rsp_ready = 0;
        @(posedge clk); #1;
        txn_a(0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        chk("store_discarded", 32'(rd != 32'h12345678), 32'h1);

        // ---- randomized ----
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      ra = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (sel == 1) ra = 32'(DEPTH * 4) + 32'($urandom_range(0, 4000));
            else               ra = 32'($urandom_range(0, DEPTH - 1) * 4);
            txn_a(1'($urandom), ra, $urandom, 4'($urandom), $urandom_range(0, 3), rd, er);
        end

        // ---- back-to-back on B, req_valid held high ----
        for (int i = 0; i < NB; i++) begin
            if (i < 8) begin
                op_w[i] = 1; op_a[i] = 32'(i * 4); op_d[i] = $urandom;
            end else begin
                op_w[i] = 0; op_a[i] = 32'($urandom_range(0, 7) * 4); op_d[i] = $urandom;
            end
        end
        op_a[NB-1] = 32'h6;
        begin
            int n_acc, n_rsp, last_acc;
            bit acc, rsp;
            n_acc = 0; n_rsp = 0; last_acc = 0;
            b_rsp_ready = 1;
            b_req_valid = 1; b_req_write = op_w[0]; b_req_addr = op_a[0];
            b_req_wdata = op_d[0]; b_req_be = 4'hF;
            for (int cyc = 0; cyc < 200 && n_rsp < NB; cyc++) begin
                acc = b_req_ready && b_req_valid;
                rsp = b_rsp_valid && b_rsp_ready;
                if (rsp) begin
                    if (exp_q_rd.size() == 0) begin
                        chk("b_unexpected_rsp", 32'h1, 32'h0);
                    end else begin
                        logic [31:0] e_rd;
                        logic        e_er;
                        e_rd = exp_q_rd.pop_front();
                        e_er = exp_q_er.pop_front();
                        chk("b_rdata", b_rsp_rdata, e_rd);
                        chk("b_err", 32'(b_rsp_err), 32'(e_er));
                        $display("txn B rsp %0d rdata=%h err=%0d", n_rsp, b_rsp_rdata, b_rsp_err);
                    end
                    n_rsp++;
                end
                @(posedge clk); #1;
                if (acc) begin
                    logic e_er;
                    e_er = ref_err(op_a[n_acc]);
                    exp_q_er.push_back(e_er);
                    exp_q_rd.push_back((op_w[n_acc] || e_er) ? 32'h0 : mdl_b[op_a[n_acc] / 4]);
                    if (op_w[n_acc] && !e_er) mdl_b[op_a[n_acc] / 4] = op_d[n_acc];
                    if (n_acc > 0) chk("b_period", 32'(cyc - last_acc), 32'(LAT_B + 2));
                    last_acc = cyc;
                    n_acc++;
                    if (n_acc < NB) begin
                        b_req_write = op_w[n_acc]; b_req_addr = op_a[n_acc];
                        b_req_wdata = op_d[n_acc];
                    end else begin
                        b_req_valid = 0;
                    end
                end
            end
            chk("b_rsp_count", 32'(n_rsp), 32'(NB));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's data port: accepts one load/store request at a time over a valid/ready handshake, models a fixed access latency, performs byte-enabled writes into a word array, and returns a response over a second valid/ready handshake. It sits between the core's load/store path and the data storage, replacing the zero-wait combinational data memory so the core can be exercised against realistic wait states.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words stored.
- `LATENCY`, 2: wait cycles between request acceptance and response; legal range 1..15.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, little-endian.
- `req_be`  in  4  byte enables; bit i covers bits 8i+7:8i.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester consumes response.
- `rsp_rdata`  out  32  load data; 0 for stores and errors.
- `rsp_err`  out  1  request was misaligned or out of range.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch write, addr, wdata, be; load wait counter with LATENCY-1; go to WAIT.
- WAIT: `req_ready`=0. Counter decrements each cycle; on the edge where it is 0, perform the access and go to RESP.
- Access: error if `addr[1:0]` != 0 or `addr[31:2]` >= DEPTH_WORDS; on error no array read or write, `rsp_err`=1, `rsp_rdata`=0. Load: `rsp_rdata` = stored word (all 4 bytes, `req_be` ignored). Store: only enabled bytes updated; `req_be`=0 is a legal no-op store with ok response.
- RESP: `rsp_valid`=1; `rsp_rdata`/`rsp_err` held stable until `rsp_valid && rsp_ready`, then go to IDLE.
- Inputs other than `req_valid` are don't-care outside the acceptance cycle.
- Array contents are not cleared by reset; uninitialised words read as X in simulation.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter 0.
- Acceptance at edge t0: `rsp_valid` rises after edge t0+LATENCY.
- Store commit occurs at edge t0+LATENCY; a later request sees the new data.
- Response consumed at edge t1: `req_ready` is 1 in the following cycle, and the next request is accepted at edge t1+1 at the earliest.
- Minimum period with `rsp_ready` tied high: LATENCY+2 cycles per transaction.
- `rsp_ready` low in RESP: stall indefinitely and hold all response outputs.
- Reset asserted mid-transaction: return to IDLE immediately and drop `rsp_valid`. A store not yet committed is discarded. Already-committed array data persists.
- `req_ready` is a combinational decode of state==IDLE and does not depend on `req_valid`, so the handshake has no combinational loop.

## Structure
- Shared package `mem_bus_pkg`: state enum (IDLE/WAIT/RESP), `BE_W`=4, `WORD_W`=32, and an address-decode helper for the alignment/range check.
- Sub-module `mem_word_array`: DEPTH_WORDS×32 storage, synchronous byte-enabled write, read sampled on the same edge as the access strobe. The FSM, counter and response registers stay in `data_mem_responder`.

## Test plan
- Store 0xDEADBEEF to 0x10 with be=0xF, then load 0x10 with LATENCY=2 and `rsp_ready`=1. Required: load `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, and `rsp_valid` rises exactly 2 cycles after each accept.
- Store 0x000000AA to 0x10 with be=0x1 over the prior value, then load 0x10. Required: `rsp_rdata`=0xDEADBEAA.
- Load from 0x12, then load from DEPTH_WORDS*4. Required: both responses have `rsp_err`=1 and `rsp_rdata`=0; a store to 0x13 leaves the array unchanged.
- Hold `rsp_ready`=0 for 5 cycles in RESP. Required: `rsp_valid`, `rsp_rdata` and `rsp_err` stay stable and `req_ready` stays 0; after release, next accept occurs one cycle after consumption.
- Store 0x12345678 to 0x20, then pull `reset` low during WAIT. Required: immediate `rsp_valid`=0 and `req_ready`=1; a subsequent load of 0x20 returns the prior value, not 0x12345678.
- Run back-to-back loads with `req_valid` held high and LATENCY=1. Required: exactly one transaction per 3 cycles, in order.
